// File: rtl/dac_pkg.sv
// Shared state type and constants for the DAC waveform player.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } dac_state_e;

    // Cycles from read issue to registered RAM output.
    localparam int RD_LAT = 2;

    function automatic logic [31:0] midscale(input int data_w);
        return 32'd1 << (data_w - 1);
    endfunction

endpackage

// File: rtl/dac_wave_ram.sv
// Simple-dual-port sample RAM: synchronous write, registered address then
// registered data on the read side. A same-edge read of a written word sees old data.
module dac_wave_ram
    import dac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] rd_addr_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_addr_q <= rd_addr;
        rd_data <= mem[rd_addr_q];
    end

endmodule

// File: rtl/dac_wave_player.sv
// Waveform playback engine: host-loaded sample RAM, rate-divided sequencer, DAC output register.
// Build option DAC_PLAYER_IDLE_HOLD_EN keeps the last sample on dac_data after playback ends.
module dac_wave_player
    import dac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] len,
    input  logic              loop_en,
    input  logic [DIV_W-1:0]  rate_div,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_strobe
);

    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale(DATA_W));

    dac_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len_q;
    logic              loop_q;
    logic [DIV_W-1:0]  rate_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [DATA_W-1:0] ram_q;
    logic              issue;

    // Stop outranks a same-cycle tick so an abort never launches another read.
    assign issue = (state == PLAY) && !stop && (div_cnt == '0);

    dac_wave_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_addr <= '0;
            addr     <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            rate_q   <= '0;
            div_cnt  <= '0;
            vld_pipe <= '0;
        end else begin
            done     <= 1'b0;
            vld_pipe <= {vld_pipe[RD_LAT-2:0], issue};
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        len_q   <= len;
                        loop_q  <= loop_en;
                        rate_q  <= rate_div;
                        div_cnt <= '0;
                        addr    <= '0;
                        busy    <= 1'b1;
                        state   <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state <= DRAIN;
                    end else if (div_cnt == '0) begin
                        cur_addr <= addr;
                        div_cnt  <= rate_q;
                        if (addr == len_q) begin
                            addr <= '0;
                            if (!loop_q)
                                state <= DRAIN;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                DRAIN: begin
                    // Samples already in the RAM pipeline still reach the DAC.
                    if (vld_pipe == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_data   <= MIDSCALE;
            dac_strobe <= 1'b0;
        end else begin
            dac_strobe <= vld_pipe[RD_LAT-1];
`ifdef DAC_PLAYER_IDLE_HOLD_EN
            if (vld_pipe[RD_LAT-1])
                dac_data <= ram_q;
`else
            if (vld_pipe[RD_LAT-1])
                dac_data <= ram_q;
            else if (done)
                dac_data <= MIDSCALE;
`endif
        end
    end

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed bench for dac_wave_player: per-cycle vector table plus hand-written
// rate, loop/stop/collision and reset sequences.
module tb_dac_wave_player;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DIV_W  = 4;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] len;
    logic              loop_en;
    logic [DIV_W-1:0]  rate_div;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] dac_data;
    logic              dac_strobe;

    int checks = 0;
    int errors = 0;

    dac_wave_player #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .len        (len),
        .loop_en    (loop_en),
        .rate_div   (rate_div),
        .busy       (busy),
        .done       (done),
        .cur_addr   (cur_addr),
        .dac_data   (dac_data),
        .dac_strobe (dac_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [3:0] len;
        logic       loop_en;
        logic [3:0] rate;
        logic       e_busy;
        logic       e_done;
        logic       e_strobe;
        logic [7:0] e_data;
        logic [3:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic st, input logic sp, input logic [3:0] l,
                                 input logic lp, input logic [3:0] r, input logic b,
                                 input logic d, input logic s, input logic [7:0] dat,
                                 input logic [3:0] a);
        vec_t v;
        v.start = st; v.stop = sp; v.len = l; v.loop_en = lp; v.rate = r;
        v.e_busy = b; v.e_done = d; v.e_strobe = s; v.e_data = dat; v.e_addr = a;
        return v;
    endfunction

    // Expected dac_data once playback has ended, given the last sample played.
    function automatic logic [7:0] idle_val(input logic [7:0] last);
`ifdef DAC_PLAYER_IDLE_HOLD_EN
        return last;
`else
        return (last == last) ? 8'h80 : 8'h80;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle; inputs set before this call are sampled on that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_d;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; len = '0; loop_en = 1'b0; rate_div = '0;
        step(); step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset strobe", dac_strobe, 0);
        chk("reset cur_addr", cur_addr, 0);
        chk("reset dac_data", dac_data, 8'h80);
        reset = 1'b0;

        wr(0, 8'h10); wr(1, 8'h11); wr(2, 8'h12); wr(3, 8'h13);

        // One-shot len=3 rate 0: start edge is row 0, strobes rows 3..6, done row 7.
        vecs.push_back(mkv(1,0,3,0,0, 1,0,0,8'h80,0));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,0,8'h80,0));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,0,8'h80,1));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,1,8'h10,2));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,1,8'h11,3));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,1,8'h12,3));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,1,8'h13,3));
        vecs.push_back(mkv(0,0,0,0,0, 0,1,0,8'h13,3));
        vecs.push_back(mkv(0,0,0,0,0, 0,0,0,idle_val(8'h13),3));
        // start+stop together in IDLE, then stop alone in IDLE: both ignored.
        vecs.push_back(mkv(1,1,3,0,0, 0,0,0,idle_val(8'h13),3));
        vecs.push_back(mkv(0,1,3,0,0, 0,0,0,idle_val(8'h13),3));
        // len=0 one-shot: single sample then done.
        vecs.push_back(mkv(1,0,0,0,0, 1,0,0,idle_val(8'h13),3));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,0,idle_val(8'h13),0));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,0,idle_val(8'h13),0));
        vecs.push_back(mkv(0,0,0,0,0, 1,0,1,8'h10,0));
        vecs.push_back(mkv(0,0,0,0,0, 0,1,0,8'h10,0));
        vecs.push_back(mkv(0,0,0,0,0, 0,0,0,idle_val(8'h10),0));

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; len = vecs[i].len;
            loop_en = vecs[i].loop_en; rate_div = vecs[i].rate;
            step();
            chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d done", i), done, vecs[i].e_done);
            chk($sformatf("vec%0d strobe", i), dac_strobe, vecs[i].e_strobe);
            chk($sformatf("vec%0d dac_data", i), dac_data, vecs[i].e_data);
            chk($sformatf("vec%0d cur_addr", i), cur_addr, vecs[i].e_addr);
        end
        start = 0; stop = 0;

        // Rate divider 2: strobes every third cycle starting 3 after start.
        start = 1; len = 3; loop_en = 0; rate_div = 2;
        step();
        start = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk($sformatf("rate k%0d strobe", k), dac_strobe, (k % 3 == 0 && k <= 12));
            chk($sformatf("rate k%0d busy", k), busy, (k <= 12));
            chk($sformatf("rate k%0d done", k), done, (k == 13));
            if (k % 3 == 0 && k <= 12)
                chk($sformatf("rate k%0d data", k), dac_data, 8'h10 + (k / 3) - 1);
            if (k == 14)
                chk("rate idle data", dac_data, idle_val(8'h13));
        end

        // Loop len=1, start-while-busy ignored, write addr 0 mid-loop, then stop.
        start = 1; len = 1; loop_en = 1; rate_div = 0;
        step();
        for (int k = 1; k <= 11; k++) begin
            start    = (k == 2);
            len      = (k == 2) ? 4'd3 : 4'd1;
            rate_div = (k == 2) ? 4'd2 : 4'd0;
            loop_en  = (k != 2);
            wr_en    = (k == 4); wr_addr = 0; wr_data = 8'h55;
            stop     = (k == 8);
            step();
            case (k)
                3, 5:    exp_d = 8'h10;
                4, 6, 8: exp_d = 8'h11;
                7, 9:    exp_d = 8'h55;
                10:      exp_d = 8'h55;
                default: exp_d = idle_val(8'h55);
            endcase
            chk($sformatf("loop k%0d strobe", k), dac_strobe, (k >= 3 && k <= 9));
            chk($sformatf("loop k%0d busy", k), busy, (k <= 9));
            chk($sformatf("loop k%0d done", k), done, (k == 10));
            if (k >= 3)
                chk($sformatf("loop k%0d data", k), dac_data, exp_d);
        end
        wr_en = 0; stop = 0; start = 0;

        // Reset during PLAY: everything back to reset values, no done afterwards.
        start = 1; len = 3; loop_en = 1; rate_div = 0;
        step();
        start = 0;
        for (int k = 1; k <= 4; k++) step();
        chk("rst pre busy", busy, 1);
        chk("rst pre data", dac_data, 8'h11);
        reset = 1;
        step();
        reset = 0;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst strobe", dac_strobe, 0);
        chk("rst data", dac_data, 8'h80);
        chk("rst cur_addr", cur_addr, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("post-rst k%0d done", k), done, 0);
            chk($sformatf("post-rst k%0d strobe", k), dac_strobe, 0);
            chk($sformatf("post-rst k%0d busy", k), busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
